// File: rtl/regfile_scoreboard.sv
// Register file with a per-register busy scoreboard for tracking outstanding writebacks.
// Reads and hazard flags are combinational; the writeback path is bypassed to the read ports.
module regfile_scoreboard #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [AW-1:0]    ReadAddr1,
    input  logic [AW-1:0]    ReadAddr2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2,
    output logic             ReadBusy1,
    output logic             ReadBusy2,
    input  logic             IssueValid,
    input  logic [AW-1:0]    IssueAddr,
    output logic             IssueStall,
    input  logic             WriteEnable,
    input  logic [AW-1:0]    WriteAddress,
    input  logic [WIDTH-1:0] WriteData,
    output logic [AW:0]      BusyCount,
    output logic             WbUnexpected
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic clr1, clr2, clr_issue;
    logic wb_valid, issue_acc, cnt_set, cnt_clr;

    assign wb_valid  = WriteEnable && (WriteAddress != '0);
    assign clr1      = wb_valid && (WriteAddress == ReadAddr1);
    assign clr2      = wb_valid && (WriteAddress == ReadAddr2);
    assign clr_issue = wb_valid && (WriteAddress == IssueAddr);

    assign ReadData1 = (ReadAddr1 == '0) ? '0 : (clr1 ? WriteData : regs[ReadAddr1]);
    assign ReadData2 = (ReadAddr2 == '0) ? '0 : (clr2 ? WriteData : regs[ReadAddr2]);
    assign ReadBusy1 = busy[ReadAddr1] && !clr1;
    assign ReadBusy2 = busy[ReadAddr2] && !clr2;

    // Only a WAW hazard stalls; a same-cycle writeback frees the slot for re-issue.
    assign IssueStall = IssueValid && busy[IssueAddr] && !clr_issue;
    assign issue_acc  = IssueValid && !IssueStall && (IssueAddr != '0);

    // Counter tracks popcount(busy): a re-issue over a clearing bit is net zero.
    assign cnt_set = issue_acc && !busy[IssueAddr];
    assign cnt_clr = wb_valid && busy[WriteAddress] && !(issue_acc && (IssueAddr == WriteAddress));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy         <= '0;
            BusyCount    <= '0;
            WbUnexpected <= 1'b0;
        end else begin
            if (wb_valid) begin
                regs[WriteAddress] <= WriteData;
                busy[WriteAddress] <= 1'b0;
            end
            if (issue_acc) begin
                busy[IssueAddr] <= 1'b1;
            end
            BusyCount    <= BusyCount + (AW+1)'(cnt_set) - (AW+1)'(cnt_clr);
            WbUnexpected <= wb_valid && !busy[WriteAddress];
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, issue/stall, writeback bypass, r0 rules, async reset.
module tb_regfile_scoreboard;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic [AW-1:0]    ReadAddr1, ReadAddr2;
    logic [WIDTH-1:0] ReadData1, ReadData2;
    logic             ReadBusy1, ReadBusy2;
    logic             IssueValid;
    logic [AW-1:0]    IssueAddr;
    logic             IssueStall;
    logic             WriteEnable;
    logic [AW-1:0]    WriteAddress;
    logic [WIDTH-1:0] WriteData;
    logic [AW:0]      BusyCount;
    logic             WbUnexpected;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .ReadAddr1    (ReadAddr1),
        .ReadAddr2    (ReadAddr2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2),
        .ReadBusy1    (ReadBusy1),
        .ReadBusy2    (ReadBusy2),
        .IssueValid   (IssueValid),
        .IssueAddr    (IssueAddr),
        .IssueStall   (IssueStall),
        .WriteEnable  (WriteEnable),
        .WriteAddress (WriteAddress),
        .WriteData    (WriteData),
        .BusyCount    (BusyCount),
        .WbUnexpected (WbUnexpected)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then changed well away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        IssueValid   = 1'b0;
        IssueAddr    = '0;
        WriteEnable  = 1'b0;
        WriteAddress = '0;
        WriteData    = '0;
    endtask

    initial begin
        idle_inputs();
        ReadAddr1 = '0;
        ReadAddr2 = '0;
        RST_N     = 1'b0;
        tick();
        tick();
        chk("rst_busycount", BusyCount, 0);
        chk("rst_wbunexp", WbUnexpected, 0);
        RST_N = 1'b1;
        tick();

        // Reset state read of r5
        ReadAddr1 = 5;
        #1;
        chk("r5_data", ReadData1, 0);
        chk("r5_busy", ReadBusy1, 0);
        chk("r5_count", BusyCount, 0);

        // Issue r3, then attempt WAW re-issue
        IssueValid = 1'b1;
        IssueAddr  = 3;
        #1;
        chk("issue_r3_nostall", IssueStall, 0);
        tick();
        ReadAddr1 = 3;
        #1;
        chk("r3_busy", ReadBusy1, 1);
        chk("r3_count", BusyCount, 1);
        chk("r3_reissue_stall", IssueStall, 1);
        tick();
        IssueValid = 1'b0;
        #1;
        chk("r3_count_after_stall", BusyCount, 1);

        // Writeback r3 with same-cycle bypass
        WriteEnable  = 1'b1;
        WriteAddress = 3;
        WriteData    = 32'hDEADBEEF;
        ReadAddr2    = 3;
        #1;
        chk("r3_bypass_data", ReadData1, 32'hDEADBEEF);
        chk("r3_bypass_busy1", ReadBusy1, 0);
        chk("r3_bypass_busy2", ReadBusy2, 0);
        tick();
        idle_inputs();
        #1;
        chk("r3_count_cleared", BusyCount, 0);
        chk("r3_stored", ReadData1, 32'hDEADBEEF);
        chk("r3_wb_expected", WbUnexpected, 0);

        // r7 busy, then same-cycle writeback and re-issue
        IssueValid = 1'b1;
        IssueAddr  = 7;
        tick();
        WriteEnable  = 1'b1;
        WriteAddress = 7;
        WriteData    = 32'h77;
        #1;
        chk("r7_reissue_nostall", IssueStall, 0);
        tick();
        idle_inputs();
        ReadAddr1 = 7;
        #1;
        chk("r7_still_busy", ReadBusy1, 1);
        chk("r7_count", BusyCount, 1);
        chk("r7_data", ReadData1, 32'h77);
        chk("r7_wb_expected", WbUnexpected, 0);

        // Unexpected writeback to non-busy r9
        WriteEnable  = 1'b1;
        WriteAddress = 9;
        WriteData    = 32'h1234;
        tick();
        idle_inputs();
        ReadAddr1 = 9;
        #1;
        chk("r9_data", ReadData1, 32'h1234);
        chk("r9_wbunexp_pulse", WbUnexpected, 1);
        chk("r9_count", BusyCount, 1);
        tick();
        chk("r9_wbunexp_drop", WbUnexpected, 0);

        // Register 0: writes and issues discarded
        WriteEnable  = 1'b1;
        WriteAddress = 0;
        WriteData    = 32'hFFFF_FFFF;
        IssueValid   = 1'b1;
        IssueAddr    = 0;
        ReadAddr2    = 0;
        #1;
        chk("r0_bypass_data", ReadData2, 0);
        chk("r0_stall", IssueStall, 0);
        chk("r0_busy", ReadBusy2, 0);
        tick();
        idle_inputs();
        #1;
        chk("r0_data", ReadData2, 0);
        chk("r0_count", BusyCount, 1);
        chk("r0_wbunexp", WbUnexpected, 0);

        // Issue r1, r2, r4 then assert reset between edges
        IssueValid = 1'b1;
        IssueAddr  = 1;
        tick();
        IssueAddr = 2;
        tick();
        IssueAddr = 4;
        tick();
        IssueValid = 1'b0;
        ReadAddr1  = 1;
        ReadAddr2  = 4;
        #1;
        chk("pre_reset_count", BusyCount, 4);
        chk("pre_reset_busy1", ReadBusy1, 1);
        chk("pre_reset_busy2", ReadBusy2, 1);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_rst_count", BusyCount, 0);
        chk("async_rst_busy1", ReadBusy1, 0);
        chk("async_rst_busy2", ReadBusy2, 0);
        ReadAddr1 = 9;
        #1;
        chk("async_rst_data", ReadData1, 0);

        // Inputs ignored while reset is held
        IssueValid = 1'b1;
        IssueAddr  = 5;
        tick();
        chk("held_rst_count", BusyCount, 0);
        RST_N = 1'b1;
        IssueValid = 1'b0;
        tick();
        chk("post_rst_count", BusyCount, 0);

        // Writeback to a reservation lost in reset
        WriteEnable  = 1'b1;
        WriteAddress = 1;
        WriteData    = 32'h5;
        ReadAddr1    = 1;
        #1;
        chk("post_rst_bypass", ReadData1, 32'h5);
        chk("post_rst_busy_comb", ReadBusy1, 0);
        tick();
        idle_inputs();
        #1;
        chk("post_rst_wbunexp", WbUnexpected, 1);
        chk("post_rst_busy", ReadBusy1, 0);
        chk("post_rst_count2", BusyCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
